// File: rtl/map_redraw_engine.sv
// Background map redraw engine. Watches the game-state code and, on a
// qualifying change, streams the affected screen rectangle from the map ROM
// to the shared VGA write port, one pixel per granted cycle.
module map_redraw_engine #(
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    parameter int COLOUR_W = 3
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [3:0]          gameState,
    input  logic                vgaGrant,
    input  logic [COLOUR_W-1:0] romData,
    output logic [16:0]         romAddr,
    output logic [3:0]          mapSel,
    output logic [8:0]          x,
    output logic [7:0]          y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                doneRedraw
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    // Inclusive rectangle bounds: origin plus last column / last row.
    typedef struct packed {
        logic [8:0] x0;
        logic [7:0] y0;
        logic [8:0] xl;
        logic [7:0] yl;
    } region_t;

    state_t     state_q, state_d;
    logic [3:0] prev_q;
    logic       boot_q, boot_d;
    logic       pend_vld_q, pend_vld_d;
    logic [3:0] pend_code_q, pend_code_d;
    logic [3:0] cur_code_q, cur_code_d;
    logic [3:0] map_sel_q, map_sel_d;
    logic       issuing_q, issuing_d;

    // Scan counters and latched rectangle (data only, loaded in LOAD).
    logic [8:0] cx_q, cx_d, x0_q, xlast_q;
    logic [7:0] cy_q, cy_d, ylast_q;

    // In-flight pixel: address issued to the ROM, colour arrives next cycle.
    logic [8:0] px_p1_q, px_p1_d;
    logic [7:0] py_p1_q, py_p1_d;
    logic       vld_p1_q, vld_p1_d;

    logic       req;
    logic       advance;
    region_t    reg_load;

    function automatic logic is_request(input logic [3:0] code);
        case (code)
            4'd0, 4'd1, 4'd3, 4'd5, 4'd7, 4'd10: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

    function automatic region_t region_of(input logic [3:0] code);
        region_t r;
        r = '{9'd0, 8'd0, 9'(SCREEN_W - 1), 8'(SCREEN_H - 1)};
        case (code)
            4'd1:    r = '{9'd96,  8'd120, 9'd159, 8'd135};
            4'd3:    r = '{9'd160, 8'd104, 9'd223, 8'd119};
            4'd5:    r = '{9'd224, 8'd88,  9'd271, 8'd103};
            4'd7:    r = '{9'd272, 8'd40,  9'd303, 8'd159};
            default: ;
        endcase
        return r;
    endfunction

    // Row stride of 320 is 256 + 64, so the multiply collapses to two shifts.
    function automatic logic [16:0] pixel_addr(input logic [8:0] ax, input logic [7:0] ay);
        if (SCREEN_W == 320)
            return ({9'd0, ay} << 8) + ({9'd0, ay} << 6) + {8'd0, ax};
        else
            return 17'(ay) * 17'(SCREEN_W) + {8'd0, ax};
    endfunction

    assign req        = (gameState != prev_q) && is_request(gameState);
    assign advance    = !vld_p1_q || vgaGrant;
    assign reg_load   = region_of(cur_code_q);

    assign plot       = (state_q == S_RUN) && vld_p1_q && vgaGrant;
    assign doneRedraw = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign x          = px_p1_q;
    assign y          = py_p1_q;
    assign colour     = romData;
    assign mapSel     = map_sel_q;
    // While stalled the in-flight address is re-issued so romData stays valid for it.
    assign romAddr    = advance ? pixel_addr(cx_q, cy_q) : pixel_addr(px_p1_q, py_p1_q);

    // Next-state logic: request capture, redraw sequencing and pixel scan.
    always_comb begin
        state_d     = state_q;
        boot_d      = boot_q;
        pend_vld_d  = pend_vld_q;
        pend_code_d = pend_code_q;
        cur_code_d  = cur_code_q;
        map_sel_d   = map_sel_q;
        issuing_d   = issuing_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        px_p1_d     = px_p1_q;
        py_p1_d     = py_p1_q;
        vld_p1_d    = vld_p1_q;

        // Any request not taken directly below lands in the pending slot.
        if (req) begin
            pend_vld_d  = 1'b1;
            pend_code_d = gameState;
        end

        unique case (state_q)
            S_IDLE: begin
                if (boot_q) begin
                    boot_d     = 1'b0;
                    cur_code_d = 4'd0;
                    state_d    = S_LOAD;
                end else if (req) begin
                    cur_code_d = gameState;
                    pend_vld_d = 1'b0;
                    state_d    = S_LOAD;
                end else if (pend_vld_q) begin
                    cur_code_d = pend_code_q;
                    pend_vld_d = 1'b0;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                map_sel_d = cur_code_q;
                cx_d      = reg_load.x0;
                cy_d      = reg_load.y0;
                issuing_d = 1'b1;
                vld_p1_d  = 1'b0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                if (advance) begin
                    if (issuing_q) begin
                        px_p1_d  = cx_q;
                        py_p1_d  = cy_q;
                        vld_p1_d = 1'b1;
                        if (cx_q == xlast_q) begin
                            cx_d = x0_q;
                            if (cy_q == ylast_q) issuing_d = 1'b0;
                            else                 cy_d = cy_q + 8'd1;
                        end else begin
                            cx_d = cx_q + 9'd1;
                        end
                    end else begin
                        vld_p1_d = 1'b0;
                    end
                end
                if (vld_p1_q && vgaGrant && !issuing_q) state_d = S_DONE;
            end
            S_DONE: begin
                if (req) begin
                    cur_code_d = gameState;
                    pend_vld_d = 1'b0;
                    state_d    = S_LOAD;
                end else if (pend_vld_q) begin
                    cur_code_d = pend_code_q;
                    pend_vld_d = 1'b0;
                    state_d    = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers and in-flight pixel; reset arms the automatic full redraw.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            prev_q      <= 4'd0;
            boot_q      <= 1'b1;
            pend_vld_q  <= 1'b0;
            pend_code_q <= 4'd0;
            cur_code_q  <= 4'd0;
            map_sel_q   <= 4'd0;
            issuing_q   <= 1'b0;
            px_p1_q     <= 9'd0;
            py_p1_q     <= 8'd0;
            vld_p1_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= gameState;
            boot_q      <= boot_d;
            pend_vld_q  <= pend_vld_d;
            pend_code_q <= pend_code_d;
            cur_code_q  <= cur_code_d;
            map_sel_q   <= map_sel_d;
            issuing_q   <= issuing_d;
            px_p1_q     <= px_p1_d;
            py_p1_q     <= py_p1_d;
            vld_p1_q    <= vld_p1_d;
        end
    end

    // Scan counters and rectangle bounds; always written before use, so no reset.
    always_ff @(posedge clock) begin
        cx_q <= cx_d;
        cy_q <= cy_d;
        if (state_q == S_LOAD) begin
            x0_q    <= reg_load.x0;
            xlast_q <= reg_load.xl;
            ylast_q <= reg_load.yl;
        end
    end

endmodule

// File: tb/tb_map_redraw_engine.sv
// Bench for map_redraw_engine: synchronous ROM model, pixel-order scoreboard,
// table-driven redraw vectors and hand-written stall/pending/reset sequences.
module tb_map_redraw_engine;

    logic        clock;
    logic        resetn;
    logic [3:0]  gameState;
    logic        vgaGrant;
    logic [2:0]  romData;
    logic [16:0] romAddr;
    logic [3:0]  mapSel;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic        doneRedraw;

    map_redraw_engine dut (
        .clock(clock), .resetn(resetn), .gameState(gameState), .vgaGrant(vgaGrant),
        .romData(romData), .romAddr(romAddr), .mapSel(mapSel), .x(x), .y(y),
        .colour(colour), .plot(plot), .busy(busy), .doneRedraw(doneRedraw)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int x;
        int y;
        int sel;
    } pix_t;

    typedef struct {
        logic [3:0] code;
        bit         rnd;
        int         plots;
        int         lat;
        int         fx, fy, lx, ly;
    } vec_t;

    pix_t expq[$];
    vec_t vt[3];
    int   rx0[16], ry0[16], rw[16], rh[16];

    int cyc = 0;
    int plots = 0, dones = 0, pix_err = 0, both_err = 0, busy_cnt = 0;
    int last_plot_cyc = 0, done_cyc = 0;
    int first_x = -1, first_y = -1, last_x = -1, last_y = -1;
    int job_base = 0;
    bit rand_grant = 1'b0;
    int n_chk = 0, n_pass = 0;

    function automatic logic [2:0] rom_f(input int sel, input int addr);
        int v;
        v = addr ^ (addr >> 3) ^ (sel * 5);
        return v[2:0];
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Synchronous map ROM: data for the address sampled at this edge.
    always @(posedge clock) romData <= rom_f(int'(mapSel), int'(romAddr));

    // Monitor: scoreboard every plotted pixel against the expected stream.
    always @(negedge clock) begin
        if (plot) begin
            if (plots == job_base) begin
                first_x = int'(x);
                first_y = int'(y);
            end
            last_x = int'(x);
            last_y = int'(y);
            last_plot_cyc = cyc;
            plots = plots + 1;
            if (expq.size() == 0) begin
                pix_err = pix_err + 1;
            end else begin
                pix_t e;
                e = expq.pop_front();
                if (int'(x) != e.x || int'(y) != e.y || int'(mapSel) != e.sel ||
                    colour != rom_f(e.sel, e.y * 320 + e.x))
                    pix_err = pix_err + 1;
            end
        end
        if (doneRedraw) begin
            dones = dones + 1;
            done_cyc = cyc;
        end
        if (plot && doneRedraw) both_err = both_err + 1;
        if (busy) busy_cnt = busy_cnt + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (rand_grant) vgaGrant = ($urandom_range(0, 7) != 0);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) tick();
    endtask

    task automatic wait_done(input int budget, input string name);
        int d0;
        int n;
        d0 = dones;
        n = 0;
        while (dones == d0 && n < budget) begin
            tick();
            n++;
        end
        check({name, " done seen"}, dones - d0, 1);
    endtask

    task automatic push_region(input int code);
        for (int yy = ry0[code]; yy < ry0[code] + rh[code]; yy++)
            for (int xx = rx0[code]; xx < rx0[code] + rw[code]; xx++)
                expq.push_back('{xx, yy, code});
    endtask

    initial begin
        int r0, c0, p0, e0, d0, b0;

        for (int i = 0; i < 16; i++) begin
            rx0[i] = 0; ry0[i] = 0; rw[i] = 320; rh[i] = 240;
        end
        rx0[1] = 96;  ry0[1] = 120; rw[1] = 64; rh[1] = 16;
        rx0[3] = 160; ry0[3] = 104; rw[3] = 64; rh[3] = 16;
        rx0[5] = 224; ry0[5] = 88;  rw[5] = 48; rh[5] = 16;
        rx0[7] = 272; ry0[7] = 40;  rw[7] = 32; rh[7] = 120;

        vt[0] = '{4'd1, 1'b0, 1024, 1027, 96,  120, 159, 135};
        vt[1] = '{4'd3, 1'b1, 1024, -1,   160, 104, 223, 119};
        vt[2] = '{4'd5, 1'b1, 768,  -1,   224, 88,  271, 103};

        resetn = 1'b0; gameState = 4'd0; vgaGrant = 1'b1;
        repeat (3) tick();
        @(negedge clock);
        check("reset plot", int'(plot), 0);
        check("reset busy", int'(busy), 0);
        check("reset doneRedraw", int'(doneRedraw), 0);
        check("reset x", int'(x), 0);
        check("reset y", int'(y), 0);
        check("reset mapSel", int'(mapSel), 0);

        // Automatic full-screen redraw after reset release.
        tick();
        push_region(0);
        job_base = plots; p0 = plots; e0 = pix_err;
        r0 = cyc;
        resetn = 1'b1;
        wait_cyc(r0 + 1);
        @(negedge clock);
        check("load busy", int'(busy), 1);
        wait_done(80000, "full");
        check("full done cycle", done_cyc - r0, 76803);
        check("full plots", plots - p0, 76800);
        check("full first x", first_x, 0);
        check("full first y", first_y, 0);
        check("full last x", last_x, 319);
        check("full last y", last_y, 239);
        check("full done count", dones, 1);
        check("full pixel stream", pix_err - e0, 0);
        @(negedge clock);
        check("full busy after", int'(busy), 0);

        // Region table vectors, fixed and randomized grant.
        for (int i = 0; i < 3; i++) begin
            push_region(int'(vt[i].code));
            job_base = plots; p0 = plots; e0 = pix_err;
            rand_grant = vt[i].rnd;
            c0 = cyc;
            gameState = vt[i].code;
            wait_done(20000, "table");
            rand_grant = 1'b0;
            vgaGrant = 1'b1;
            check("table plots", plots - p0, vt[i].plots);
            if (vt[i].lat >= 0) check("table done cycle", done_cyc - c0, vt[i].lat);
            else                check("table done after last plot", done_cyc, last_plot_cyc + 1);
            check("table first x", first_x, vt[i].fx);
            check("table first y", first_y, vt[i].fy);
            check("table last x", last_x, vt[i].lx);
            check("table last y", last_y, vt[i].ly);
            check("table mapSel", int'(mapSel), int'(vt[i].code));
            check("table pixel stream", pix_err - e0, 0);
            check("table queue drained", expq.size(), 0);
            @(negedge clock);
            check("table busy after", int'(busy), 0);
        end

        // Non-qualifying codes never start a redraw.
        p0 = plots; d0 = dones; b0 = busy_cnt;
        tick(); gameState = 4'd4;
        repeat (10) tick();
        gameState = 4'd8;
        repeat (10) tick();
        gameState = 4'd9;
        repeat (10) tick();
        check("nonqual plots", plots - p0, 0);
        check("nonqual dones", dones - d0, 0);
        check("nonqual busy cycles", busy_cnt - b0, 0);

        // Pending request, then a request landing on the DONE cycle.
        push_region(1); push_region(3); push_region(5);
        job_base = plots; p0 = plots; e0 = pix_err; d0 = dones;
        c0 = cyc;
        gameState = 4'd1;
        wait_cyc(c0 + 50);
        gameState = 4'd2;
        wait_cyc(c0 + 60);
        gameState = 4'd3;
        wait_done(5000, "pend first");
        check("pend first done cycle", done_cyc - c0, 1027);
        @(negedge clock);
        check("pend load follows done", int'(busy), 1);
        wait_cyc(c0 + 2054);
        gameState = 4'd5;
        tick();
        check("pend second done count", dones - d0, 2);
        check("pend second done cycle", done_cyc - c0, 2054);
        @(negedge clock);
        check("same-cycle load busy", int'(busy), 1);
        wait_done(5000, "same-cycle");
        check("same-cycle done cycle", done_cyc - c0, 2825);
        check("chain plots", plots - p0, 2816);
        check("chain mapSel", int'(mapSel), 5);
        check("chain pixel stream", pix_err - e0, 0);
        check("chain queue drained", expq.size(), 0);

        // Grant withdrawn for 5 cycles at pixel 100 of the code-7 redraw.
        tick();
        push_region(7);
        job_base = plots; p0 = plots; e0 = pix_err;
        c0 = cyc;
        gameState = 4'd7;
        wait_cyc(c0 + 103);
        check("stall plots before", plots - p0, 100);
        vgaGrant = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("stall plot low", int'(plot), 0);
            check("stall romAddr held", int'(romAddr), 43 * 320 + 276);
            tick();
        end
        vgaGrant = 1'b1;
        wait_done(10000, "stall");
        check("stall done cycle", done_cyc - c0, 3848);
        check("stall plots", plots - p0, 3840);
        check("stall pixel stream", pix_err - e0, 0);
        check("stall queue drained", expq.size(), 0);

        // Reset at pixel 500 of a code-5 redraw with a request pending.
        push_region(5);
        job_base = plots; p0 = plots; e0 = pix_err;
        c0 = cyc;
        gameState = 4'd5;
        wait_cyc(c0 + 200);
        gameState = 4'd3;
        wait_cyc(c0 + 400);
        gameState = 4'd4;
        wait_cyc(c0 + 503);
        gameState = 4'd0;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("reset mid plots", plots - p0, 501);
        expq.delete();
        push_region(0);
        job_base = plots; p0 = plots;
        @(negedge clock);
        check("mid reset plot", int'(plot), 0);
        check("mid reset busy", int'(busy), 0);
        check("mid reset doneRedraw", int'(doneRedraw), 0);
        tick();
        @(negedge clock);
        check("restart load busy", int'(busy), 1);
        wait_cyc(c0 + 1507);
        check("restart plots", plots - p0, 1000);
        check("restart mapSel", int'(mapSel), 0);
        check("restart first x", first_x, 0);
        check("restart first y", first_y, 0);
        check("restart last x", last_x, 39);
        check("restart last y", last_y, 3);
        check("restart pixel stream", pix_err - e0, 0);
        check("plot/done overlap", both_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/map_redraw_engine.md
Name: map_redraw_engine

Overview:
- Background redraw engine downstream of the game-state FSM.
- Watches the 4-bit gameState code. On a qualifying change it streams the affected screen rectangle from the map ROM to the VGA adapter, one pixel per granted cycle.
- Pulses doneRedraw on completion, which advances the FSM out of its DRAW/UPDATE states.
- Shares the VGA write port with the sprite drawer through vgaGrant.

Parameters:
- SCREEN_W, 320, screen width in pixels; also the ROM row stride.
- SCREEN_H, 240, screen height in pixels.
- COLOUR_W, 3, colour width in bits.

Ports:
- clock  in  1  system clock
- resetn  in  1  reset; synchronous, active-low
- gameState  in  4  current game-state code
- vgaGrant  in  1  1 = engine may plot this cycle; 0 = stall
- romData  in  COLOUR_W  map ROM read data; synchronous, valid the cycle after the address is sampled
- romAddr  out  17  map ROM address, y*SCREEN_W + x; combinational
- mapSel  out  4  image selector for the ROM; the gameState value latched at redraw start
- x  out  9  plot x
- y  out  8  plot y
- colour  out  COLOUR_W  plot colour; equals romData
- plot  out  1  VGA write strobe
- busy  out  1  1 from LOAD through DONE inclusive
- doneRedraw  out  1  one-cycle completion pulse

Behaviour:
- Reset values: plot=0, doneRedraw=0, busy=0, x=0, y=0, mapSel=0, prevState=0, pending cleared.
- The state entered on the cycle after reset deasserts is LOAD with the full-screen region. The initial draw is automatic.
- Region table (x0, y0, w, h):
  - Codes 0 and 10, full screen: 0,0,320,240.
  - Code 1: 96,120,64,16.
  - Code 3: 160,104,64,16.
  - Code 5: 224,88,48,16.
  - Code 7: 272,40,32,120.
- Trigger: gameState != prevState, where prevState is updated every cycle.
  - New value in {0,1,3,5,7,10} is a request.
  - Any other value (2,4,6,8,9, 11–15) produces no redraw.
- FSM states IDLE, LOAD, RUN, DONE.
  - IDLE: request → LOAD.
  - LOAD (1 cycle): latch region and mapSel; counters cx=x0, cy=y0. → RUN.
  - RUN: issue and plot are pipelined.
    - romAddr = addr(cx,cy) for the next pixel when advancing, else addr of the in-flight pixel.
    - In-flight pixel P (px,py,pvalid) is plotted when pvalid & vgaGrant: plot=1, x=px, y=py, colour=romData.
    - Advance when vgaGrant | !pvalid.
    - Counters scan x-major: cx++ until x0+w-1, then cx=x0, cy++.
    - After the last pixel is plotted → DONE.
  - DONE (1 cycle): doneRedraw=1, busy stays 1. → LOAD if pending, else IDLE.
- Stall (vgaGrant=0):
  - Counters and P are frozen; plot=0.
  - romAddr holds P's address, so romData stays valid for P.
  - No pixel is lost or duplicated on resume.
- Throughput: with vgaGrant held 1, one pixel per cycle.
  - Cycle 0: gameState changes. Cycle 1: LOAD. Cycle 2: first address issued. Cycle 3: first plot.
  - Last plot is on cycle N+2; doneRedraw on cycle N+3, where N = w*h.
- Request while busy:
  - Stored in a single-entry pending slot; the latest request wins.
  - Served via DONE→LOAD. The current redraw is never aborted.
- Request in the same cycle as DONE: goes to pending, then LOAD on the next cycle.
- Arithmetic: romAddr = cy*320 + cx, built as (cy<<8)+(cy<<6)+cx in 17 bits; maximum 76799, no overflow.
- Reset mid-redraw (resetn=0 on any cycle): on the next edge, the plot, doneRedraw and busy outputs are 0 and pending is cleared. After release, a full-screen redraw restarts.
- romData is never sampled when pvalid=0.
- plot and doneRedraw are never high in the same cycle.

Test Plan:
- Reset release, vgaGrant=1 → full-screen redraw:
  - 76800 plot pulses, first (0,0), last (319,239).
  - doneRedraw exactly once, on cycle 76803 after LOAD-1; busy=0 afterward.
- gameState 0→1, vgaGrant=1 → 1024 plots in x-major order from (96,120) to (159,135), mapSel=1.
  - doneRedraw on cycle 1027 after the change.
- During the code-7 redraw, drop vgaGrant for 5 cycles at pixel 100 → plot=0 for 5 cycles, romAddr held.
  - Resume at pixel 100 with correct colour; total plots 3840; doneRedraw delayed by exactly 5 cycles.
- gameState 1→2→3 while the code-1 redraw is busy → code 2 produces no request; code 3 is pending.
  - DONE is followed immediately by LOAD; the region 160,104,64,16 is drawn; two doneRedraw pulses total.
- gameState 4→8→9 → no plot, busy stays 0, doneRedraw stays 0.
- resetn=0 for 1 cycle at pixel 500 of a code-5 redraw → outputs cleared next cycle.
  - Full-screen redraw follows; no stale pending request.
